wb_emem_arb: RTL and testbench

//  Two-master Wishbone arbiter in front of the SPI external-memory slave (wb_emem).

---
 rtl/wb_emem_arb_pkg.sv | 20 ++
 rtl/wb_emem_arb_pick.sv | 35 +++
 rtl/wb_emem_arb.sv | 158 +++++++++++++++
 tb/tb_wb_emem_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_emem_arb_pkg.sv
// Shared encodings and defaults for the wb_emem two-master arbiter.
// Imported by the arbiter top and its winner-select sub-module.
package wb_emem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam logic OWN_M0 = 1'b0;
   localparam logic OWN_M1 = 1'b1;

   localparam int STARVE_MAX_DEF = 4;
   localparam int TIMEOUT_DEF    = 255;

   localparam int SCW = 8;
   localparam int TCW = 8;

endpackage

// File: rtl/wb_emem_arb_pick.sv
// Combinational winner select for the two masters.
// Also produces the next starvation count for M0.
module wb_emem_arb_pick
   import wb_emem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic           req0,
   input  logic           req1,
   input  logic [SCW-1:0] starve_cnt,
   output logic           grant,
   output logic [SCW-1:0] starve_nxt
);

   logic m1_wins;

   assign m1_wins = req1 &&
      (!req0 || (starve_cnt < SCW'(STARVE_MAX)));

   always_comb begin
      grant      = OWN_M0;
      starve_nxt = starve_cnt;
      if (m1_wins) begin
         grant = OWN_M1;
      end
      if (m1_wins && req0) begin
         if (starve_cnt != '1) begin
            starve_nxt = starve_cnt + 1'b1;
         end
      end else if (!m1_wins && req0) begin
         starve_nxt = '0;
      end
   end

endmodule

// File: rtl/wb_emem_arb.sv
// Two-master Wishbone arbiter in front of the SPI external-memory slave.
// Holds the winning request stable for the whole slave transfer.
module wb_emem_arb
   import wb_emem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i
);

   state_t         state;
   state_t         state_nxt;
   logic           owner;
   logic           abort;
   logic           rerr;
   logic [31:0]    rdat;
   logic [TCW-1:0] tmo_cnt;
   logic [SCW-1:0] starve_cnt;
   logic [SCW-1:0] starve_nxt;
   logic           grant;
   logic           req0;
   logic           req1;
   logic           own_cyc;
   logic           timeout;
   logic           resp;

   assign req0    = m0_stb_i & m0_cyc_i;
   assign req1    = m1_stb_i & m1_cyc_i;
   assign own_cyc = (owner == OWN_M1) ? m1_cyc_i : m0_cyc_i;
   assign timeout = (tmo_cnt == TCW'(TIMEOUT - 1));

   wb_emem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .req0       (req0),
      .req1       (req1),
      .starve_cnt (starve_cnt),
      .grant      (grant),
      .starve_nxt (starve_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (s_ack_i || timeout) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= OWN_M0;
         abort      <= 1'b0;
         rerr       <= 1'b0;
         rdat       <= '0;
         tmo_cnt    <= '0;
         starve_cnt <= '0;
         s_adr_o    <= '0;
         s_dat_o    <= '0;
         s_we_o     <= 1'b0;
         s_sel_o    <= '0;
      end else if (state == IDLE) begin
         if (req0 || req1) begin
            owner      <= grant;
            starve_cnt <= starve_nxt;
            tmo_cnt    <= '0;
            abort      <= 1'b0;
            rerr       <= 1'b0;
            rdat       <= '0;
            if (grant == OWN_M1) begin
               s_adr_o <= m1_adr_i;
               s_dat_o <= m1_dat_i;
               s_we_o  <= m1_we_i;
               s_sel_o <= m1_sel_i;
            end else begin
               s_adr_o <= m0_adr_i;
               s_dat_o <= m0_dat_i;
               s_we_o  <= m0_we_i;
               s_sel_o <= m0_sel_i;
            end
         end
      end else if (state == BUSY) begin
         tmo_cnt <= tmo_cnt + 1'b1;
         // A master that walks away still lets the SPI transfer finish.
         if (!own_cyc) begin
            abort <= 1'b1;
         end
         if (s_ack_i) begin
            rdat <= s_we_o ? '0 : s_dat_i;
         end else if (timeout) begin
            rerr <= 1'b1;
            rdat <= '0;
         end
      end
   end

   assign s_stb_o = (state == BUSY);
   assign s_cyc_o = (state == BUSY);

   assign resp     = (state == RESP) && !abort;
   assign m0_ack_o = resp && !rerr && (owner == OWN_M0);
   assign m1_ack_o = resp && !rerr && (owner == OWN_M1);
   assign m0_err_o = resp && rerr && (owner == OWN_M0);
   assign m1_err_o = resp && rerr && (owner == OWN_M1);
   assign m0_dat_o = m0_ack_o ? rdat : '0;
   assign m1_dat_o = m1_ack_o ? rdat : '0;

endmodule

// File: tb/tb_wb_emem_arb.sv
// Directed bench for wb_emem_arb with an expected-grant scoreboard.
module tb_wb_emem_arb;

   logic        clk;
   logic        rst_n;
   logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
   logic        m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
   logic [3:0]  m0_sel_i;
   logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
   logic        m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
   logic [3:0]  m1_sel_i;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
   logic [3:0]  s_sel_o;

   typedef struct {
      bit          m;
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
      logic [3:0]  sel;
   } exp_t;

   exp_t exp_q[$];
   int   cmp;
   int   mism;

   wb_emem_arb dut (
      .clk(clk), .rst_n(rst_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
      .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m0_dat_o(m0_dat_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
      .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .m1_dat_o(m1_dat_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(string tag, logic [31:0] obs,
                      logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_m(bit m, logic [31:0] adr,
                          logic [31:0] dat, logic we,
                          logic [3:0] sel, logic req);
      if (m) begin
         m1_adr_i = adr; m1_dat_i = dat; m1_we_i = we;
         m1_sel_i = sel; m1_stb_i = req; m1_cyc_i = req;
      end else begin
         m0_adr_i = adr; m0_dat_i = dat; m0_we_i = we;
         m0_sel_i = sel; m0_stb_i = req; m0_cyc_i = req;
      end
   endtask

   task automatic push(bit m, logic [31:0] adr,
                       logic [31:0] dat, logic we,
                       logic [3:0] sel);
      exp_t e;
      e.m = m; e.adr = adr; e.dat = dat;
      e.we = we; e.sel = sel;
      exp_q.push_back(e);
   endtask

   task automatic wait_stb();
      int n;
      n = 0;
      while (!s_stb_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stb_wait", 32'(n < 50), 32'd1);
   endtask

   task automatic pop_chk(output exp_t e);
      chk("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
      end else begin
         e.m = 0; e.adr = 0; e.dat = 0; e.we = 0; e.sel = 0;
      end
      chk("s_adr", s_adr_o, e.adr);
      chk("s_dat", s_dat_o, e.dat);
      chk("s_we", 32'(s_we_o), 32'(e.we));
      chk("s_sel", 32'(s_sel_o), 32'(e.sel));
   endtask

   task automatic serve(int dly, logic [31:0] rd, bit drop);
      exp_t e;
      logic [31:0] xd;
      wait_stb();
      pop_chk(e);
      repeat (dly) @(negedge clk);
      chk("adr_hold", s_adr_o, e.adr);
      s_ack_i = 1'b1;
      s_dat_i = rd;
      @(negedge clk);
      s_ack_i = 1'b0;
      s_dat_i = '0;
      xd = e.we ? 32'h0 : rd;
      chk("stb_gap", 32'(s_stb_o), 32'd0);
      chk("own_ack", 32'(e.m ? m1_ack_o : m0_ack_o), 32'd1);
      chk("own_dat", e.m ? m1_dat_o : m0_dat_o, xd);
      chk("oth_ack", 32'(e.m ? m0_ack_o : m1_ack_o), 32'd0);
      chk("oth_dat", e.m ? m0_dat_o : m1_dat_o, 32'd0);
      chk("err_lo", 32'(m0_err_o | m1_err_o), 32'd0);
      if (drop) begin
         drive_m(e.m, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic chk_idle_outs(string tag);
      chk({tag, "_stb"}, 32'(s_stb_o), 32'd0);
      chk({tag, "_cyc"}, 32'(s_cyc_o), 32'd0);
      chk({tag, "_adr"}, s_adr_o, 32'd0);
      chk({tag, "_sdat"}, s_dat_o, 32'd0);
      chk({tag, "_ack"}, 32'(m0_ack_o | m1_ack_o), 32'd0);
      chk({tag, "_err"}, 32'(m0_err_o | m1_err_o), 32'd0);
      chk({tag, "_mdat"}, m0_dat_o | m1_dat_o, 32'd0);
   endtask

   initial begin
      exp_t e;
      int   n;
      cmp = 0;
      mism = 0;
      rst_n = 1'b0;
      s_ack_i = 1'b0;
      s_dat_i = '0;
      drive_m(0, 0, 0, 0, 0, 0);
      drive_m(1, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk_idle_outs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single M0 read, slow slave
      drive_m(0, 32'h100, 0, 0, 4'hf, 1);
      push(0, 32'h100, 0, 0, 4'hf);
      @(negedge clk);
      chk("t1_stb_lat", 32'(s_stb_o), 32'd1);
      serve(70, 32'hDEADBEEF, 1);

      // 2: simultaneous request, M1 first then M0
      drive_m(0, 32'h104, 0, 0, 4'hf, 1);
      drive_m(1, 32'h200, 32'h11223344, 1, 4'b0011, 1);
      push(1, 32'h200, 32'h11223344, 1, 4'b0011);
      push(0, 32'h104, 0, 0, 4'hf);
      serve(3, 32'h0BADF00D, 1);
      serve(3, 32'hCAFE0001, 1);

      // 3: both requesting back-to-back
      drive_m(0, 32'h400, 0, 0, 4'hf, 1);
      drive_m(1, 32'h500, 32'hA5A5A5A5, 1, 4'hf, 1);
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            push(1, 32'h500, 32'hA5A5A5A5, 1, 4'hf);
         push(0, 32'h400, 0, 0, 4'hf);
      end
      for (int k = 0; k < 9; k++) serve(2, 32'h1000 + k, 0);
      serve(2, 32'h2000, 1);
      drive_m(1, 0, 0, 0, 0, 0);

      // 4: slave never answers
      @(negedge clk);
      drive_m(1, 32'h600, 0, 0, 4'hf, 1);
      push(1, 32'h600, 0, 0, 4'hf);
      wait_stb();
      pop_chk(e);
      n = 0;
      while (!m1_err_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("t4_tmo_cycles", 32'(n), 32'd255);
      chk("t4_ack", 32'(m1_ack_o), 32'd0);
      chk("t4_dat", m1_dat_o, 32'd0);
      chk("t4_stb", 32'(s_stb_o), 32'd0);
      drive_m(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      s_ack_i = 1'b1;
      s_dat_i = 32'h77777777;
      @(negedge clk);
      s_ack_i = 1'b0;
      s_dat_i = '0;
      chk("t4_late_ack", 32'(m0_ack_o | m1_ack_o), 32'd0);
      chk("t4_late_err", 32'(m0_err_o | m1_err_o), 32'd0);
      chk("t4_late_stb", 32'(s_stb_o), 32'd0);

      // 5: M0 abandons its cycle mid-transfer
      drive_m(0, 32'h300, 0, 0, 4'hf, 1);
      push(0, 32'h300, 0, 0, 4'hf);
      wait_stb();
      pop_chk(e);
      repeat (10) @(negedge clk);
      drive_m(0, 0, 0, 0, 0, 0);
      drive_m(1, 32'h340, 0, 0, 4'h3, 1);
      repeat (20) @(negedge clk);
      chk("t5_adr_hold", s_adr_o, 32'h300);
      chk("t5_stb_hold", 32'(s_stb_o), 32'd1);
      s_ack_i = 1'b1;
      s_dat_i = 32'h99999999;
      @(negedge clk);
      s_ack_i = 1'b0;
      s_dat_i = '0;
      chk("t5_no_ack", 32'(m0_ack_o | m1_ack_o), 32'd0);
      chk("t5_no_err", 32'(m0_err_o | m1_err_o), 32'd0);
      chk("t5_no_dat", m0_dat_o, 32'd0);
      push(1, 32'h340, 0, 0, 4'h3);
      serve(2, 32'h34343434, 1);

      // 6: reset mid-BUSY with starvation count at its limit
      drive_m(0, 32'h700, 0, 0, 4'hf, 1);
      drive_m(1, 32'h800, 32'h55, 1, 4'hf, 1);
      for (int k = 0; k < 4; k++) push(1, 32'h800, 32'h55, 1, 4'hf);
      for (int k = 0; k < 3; k++) serve(2, 32'h0, 0);
      wait_stb();
      pop_chk(e);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_idle_outs("t6_rst");
      @(negedge clk);
      rst_n = 1'b1;
      push(1, 32'h800, 32'h55, 1, 4'hf);
      push(0, 32'h700, 0, 0, 4'hf);
      serve(2, 32'h0, 1);
      serve(2, 32'h70707070, 1);
      chk("q_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp, mism);
      $finish;
   end

endmodule
